// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared constants, response tag type and one-hot helper for
// the data-memory arbiter. Tag index is sized for the largest supported
// requester count (8) so the struct does not depend on the instance parameter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_NUM_REQ = 4;
  localparam int unsigned MAX_REQ      = 8;
  localparam int unsigned TAG_IDX_W    = 3;

  // Tag of the access issued last cycle; pend marks a response due now.
  typedef struct packed {
    logic                 pend;
    logic [TAG_IDX_W-1:0] idx;
  } rsp_tag_t;

  // Decode a requester index into a one-hot vector of MAX_REQ bits.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [TAG_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational rotating-priority encoder.
// Ports:
//   valid_i        - per-requester request vector
//   ptr_i          - index holding the highest priority this cycle
//   grant_onehot_o - one-hot winner (zero when nothing is valid)
//   grant_idx_o    - winner index (zero when nothing is valid)
//   any_grant_o    - at least one requester is valid
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_onehot_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_grant_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk ptr_i, ptr_i+1, ... modulo NUM_REQ and take the first valid entry.
  always_comb begin
    grant_onehot_o = '0;
    grant_idx_o    = '0;
    found          = 1'b0;
    cand           = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && valid_i[cand]) begin
        found                = 1'b1;
        grant_idx_o          = cand;
        grant_onehot_o[cand] = 1'b1;
      end
    end
    any_grant_o = found;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one single-port data BRAM among
// NUM_REQ requesters. One access per cycle; the response (read data or write
// ack) is returned one cycle after issue, tagged with the requester's bit.
// Optional feature macro: DMEM_ARB_LOCK_EN adds req_lock_i, which lets the
// granted requester keep exclusive access for a read-modify-write sequence.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   req_valid_i   - per-requester request
//   req_lock_i    - per-requester lock request (DMEM_ARB_LOCK_EN only)
//   req_we_i      - per-requester write (1) / read (0)
//   req_addr_i    - packed addresses, requester i at [i*WIDTH +: WIDTH]
//   req_wdata_i   - packed write data, same packing
//   req_ready_o   - one-hot grant, combinational
//   rsp_valid_o   - one-hot response strobe, one cycle after grant
//   rsp_rdata_o   - read data (pass-through of dm_rdata_i)
//   dm_we_o, dm_addr_o, dm_wdata_o - BRAM command, combinational
//   dm_rdata_i    - BRAM read data, one cycle after address
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_REQ = DMEM_NUM_REQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]       req_lock_i,
`endif
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WIDTH-1:0]         rsp_rdata_o,
  output logic                     dm_we_o,
  output logic [WIDTH-1:0]         dm_addr_o,
  output logic [WIDTH-1:0]         dm_wdata_o,
  input  logic [WIDTH-1:0]         dm_rdata_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   prio_ptr_q, prio_ptr_d;
  rsp_tag_t           tag_q, tag_d;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant_oh;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_grant;

`ifdef DMEM_ARB_LOCK_EN
  logic               lock_own_q, lock_own_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

  // While locked, only the lock owner is eligible.
  assign elig = lock_own_q
              ? (req_valid_i & NUM_REQ'(onehot(TAG_IDX_W'(lock_idx_q))))
              : req_valid_i;
`else
  assign elig = req_valid_i;
`endif

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid_i        (elig),
    .ptr_i          (prio_ptr_q),
    .grant_onehot_o (grant_oh),
    .grant_idx_o    (grant_idx),
    .any_grant_o    (any_grant)
  );

  // BRAM command mux; all zero when nothing is granted.
  always_comb begin
    req_ready_o = grant_oh;
    dm_we_o     = 1'b0;
    dm_addr_o   = '0;
    dm_wdata_o  = '0;
    if (any_grant) begin
      dm_we_o    = req_we_i[grant_idx];
      dm_addr_o  = req_addr_i[32'(grant_idx) * WIDTH +: WIDTH];
      dm_wdata_o = req_wdata_i[32'(grant_idx) * WIDTH +: WIDTH];
    end
  end

  // Next-state: pointer rotation, response tag and lock ownership.
  always_comb begin
    prio_ptr_d = prio_ptr_q;
    tag_d      = '0;
`ifdef DMEM_ARB_LOCK_EN
    lock_own_d = lock_own_q;
    lock_idx_d = lock_idx_q;
`endif
    if (any_grant) begin
      prio_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      tag_d.pend = 1'b1;
      tag_d.idx  = TAG_IDX_W'(grant_idx);
`ifdef DMEM_ARB_LOCK_EN
      // Any grant while locked goes to the owner, so this both sets and clears.
      lock_own_d = req_lock_i[grant_idx];
      lock_idx_d = grant_idx;
`endif
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_q <= '0;
      tag_q      <= '0;
`ifdef DMEM_ARB_LOCK_EN
      lock_own_q <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      prio_ptr_q <= prio_ptr_d;
      tag_q      <= tag_d;
`ifdef DMEM_ARB_LOCK_EN
      lock_own_q <= lock_own_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  // Gating with rst drops an in-flight response in the reset cycle itself.
  assign rsp_valid_o = (tag_q.pend && !rst) ? NUM_REQ'(onehot(tag_q.idx)) : '0;
  assign rsp_rdata_o = dm_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven grant checks plus a response scoreboard for
// dmem_arbiter (NUM_REQ=4, WIDTH=32) with a behavioural BRAM attached.
module tb_dmem_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 32;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_we;
  logic [N*W-1:0] req_addr;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_rdata;
  logic           dm_we;
  logic [W-1:0]   dm_addr;
  logic [W-1:0]   dm_wdata;
  logic [W-1:0]   dm_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  dmem_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
`ifdef DMEM_ARB_LOCK_EN
    .req_lock_i  (req_lock),
`endif
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_rdata_o (rsp_rdata),
    .dm_we_o     (dm_we),
    .dm_addr_o   (dm_addr),
    .dm_wdata_o  (dm_wdata),
    .dm_rdata_i  (dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural BRAM: registered read, write on we.
  logic [W-1:0] bram [256];
  always @(posedge clk) begin
    if (dm_we) bram[dm_addr[7:0]] <= dm_wdata;
    dm_rdata <= bram[dm_addr[7:0]];
  end

  typedef struct {
    logic [N-1:0] oh;
    logic         rd;
    logic [W-1:0] data;
  } exp_rsp_t;

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] we;
    logic [N-1:0] exp_ready;
  } vec_t;

  exp_rsp_t     sbq[$];
  logic [W-1:0] ref_mem [256];
  int           m_ptr;
  int           chk_cnt;
  int           pass_cnt;
  logic [N-1:0] last_ready;
`ifdef DMEM_ARB_LOCK_EN
  logic         m_lock_own;
  int           m_lock_idx;
`endif

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference round-robin pick from the bench's own pointer.
  function automatic logic [N-1:0] model_pick(input logic [N-1:0] v);
    logic [N-1:0] ve;
    int           i;
    ve = v;
`ifdef DMEM_ARB_LOCK_EN
    if (m_lock_own) ve = v & (N'(1) << m_lock_idx);
`endif
    for (int k = 0; k < int'(N); k++) begin
      i = (m_ptr + k) % int'(N);
      if (ve[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  // Compare (or expect idle) the response visible this cycle.
  task automatic check_rsp();
    exp_rsp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("rsp_valid", W'(rsp_valid), W'(e.oh));
      if (e.rd) chk("rsp_rdata", rsp_rdata, e.data);
    end else begin
      chk("rsp_idle", W'(rsp_valid), '0);
    end
  endtask

  // Inputs already driven: check the grant path, book the response, clock.
  task automatic drive_cycle(input string name, input logic [N-1:0] exp_oh);
    int       g;
    exp_rsp_t e;
    logic [W-1:0] a;
    #1;
    last_ready = req_ready;
    chk({name, "_ready"}, W'(req_ready), W'(exp_oh));
    g = -1;
    for (int i = 0; i < int'(N); i++) if (exp_oh[i]) g = i;
    if (g >= 0) begin
      a = req_addr[g*W +: W];
      chk({name, "_dm_we"},    W'(dm_we), W'(req_we[g]));
      chk({name, "_dm_addr"},  dm_addr, a);
      chk({name, "_dm_wdata"}, dm_wdata, req_wdata[g*W +: W]);
      e.oh   = exp_oh;
      e.rd   = !req_we[g];
      e.data = ref_mem[a[7:0]];
      sbq.push_back(e);
      if (req_we[g]) ref_mem[a[7:0]] = req_wdata[g*W +: W];
      m_ptr = (g == int'(N) - 1) ? 0 : g + 1;
`ifdef DMEM_ARB_LOCK_EN
      m_lock_own = req_lock[g];
      m_lock_idx = g;
`endif
    end else begin
      chk({name, "_idle_we"},    W'(dm_we), '0);
      chk({name, "_idle_addr"},  dm_addr, '0);
      chk({name, "_idle_wdata"}, dm_wdata, '0);
    end
    @(posedge clk);
    @(negedge clk);
    check_rsp();
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_we    = '0;
    rst       = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    sbq.delete();
`ifdef DMEM_ARB_LOCK_EN
    req_lock   = '0;
    m_lock_own = 1'b0;
    m_lock_idx = 0;
`endif
  endtask

  vec_t vecs[9];
  int   wait1;

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    m_ptr    = 0;
    rst      = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    req_lock   = '0;
    m_lock_own = 1'b0;
    m_lock_idx = 0;
`endif
    for (int i = 0; i < 256; i++) begin
      bram[i]    = 32'hA000_0000 | W'(i);
      ref_mem[i] = 32'hA000_0000 | W'(i);
    end
    bram[8'h40]    = 32'hDEAD_BEEF;
    ref_mem[8'h40] = 32'hDEAD_BEEF;
    for (int i = 0; i < int'(N); i++) begin
      req_addr[i*W +: W]  = 32'h40 + W'(i);
      req_wdata[i*W +: W] = 32'h5500 + W'(i);
    end

    vecs[0] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[1] = '{4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{4'b0001, 4'b0000, 4'b0001};
    vecs[3] = '{4'b1001, 4'b0000, 4'b1000};
    vecs[4] = '{4'b0110, 4'b0100, 4'b0010};
    vecs[5] = '{4'b0110, 4'b0100, 4'b0100};
    vecs[6] = '{4'b0111, 4'b0000, 4'b0001};
    vecs[7] = '{4'b0100, 4'b0000, 4'b0100};
    vecs[8] = '{4'b1000, 4'b0000, 4'b1000};

    // Reset state
    @(negedge clk);
    chk("rst_ready", W'(req_ready), '0);
    chk("rst_rsp",   W'(rsp_valid), '0);
    chk("rst_dm_we", W'(dm_we), '0);
    do_reset();
    chk("post_rst_rsp", W'(rsp_valid), '0);

    // Table: single read, idle, pointer wrap, mixed read/write
    foreach (vecs[i]) begin
      req_valid = vecs[i].valid;
      req_we    = vecs[i].we;
      drive_cycle($sformatf("vec%0d", i), vecs[i].exp_ready);
    end
    req_valid = '0;
    req_we    = '0;
    drive_cycle("drain0", '0);

    // All valid: strict rotation 0,1,2,3,...
    do_reset();
    req_valid = '1;
    for (int k = 0; k < 8; k++) drive_cycle($sformatf("rot%0d", k), N'(1) << (k % 4));
    req_valid = '0;
    drive_cycle("drain1", '0);

    // Write then read of the same address by different requesters
    req_addr[0*W +: W]  = 32'h10;
    req_wdata[0*W +: W] = 32'h1234;
    req_addr[2*W +: W]  = 32'h10;
    req_valid = 4'b0001;
    req_we    = 4'b0001;
    drive_cycle("wr0", 4'b0001);
    req_valid = 4'b0100;
    req_we    = 4'b0000;
    drive_cycle("rd2", 4'b0100);
    req_valid = '0;
    drive_cycle("drain2", '0);
    chk("raw_data", ref_mem[8'h10], 32'h0000_1234);

    // Fairness: req0 and req1 both hammering
    req_valid = 4'b0011;
    wait1 = 0;
    for (int k = 0; k < 6; k++) begin
      drive_cycle($sformatf("fair%0d", k), model_pick(req_valid));
      wait1 = last_ready[1] ? 0 : wait1 + 1;
      chk("req1_wait_bound", W'(wait1 <= int'(N) - 1), 32'd1);
    end
    req_valid = '0;
    drive_cycle("drain3", '0);

    // Reset while a read is in flight
    req_valid = 4'b0010;
    #1;
    chk("mid_grant", W'(req_ready), W'(model_pick(req_valid)));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    #1;
    chk("mid_rsp_drop_n1", W'(rsp_valid), '0);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_ptr = 0;
    chk("mid_rsp_drop_n2", W'(rsp_valid), '0);
    req_valid = 4'b1100;
    drive_cycle("post_mid", 4'b0100);
    req_valid = '0;
    drive_cycle("drain4", '0);

`ifdef DMEM_ARB_LOCK_EN
    // Lock: req3 keeps the BRAM for its read-modify-write
    do_reset();
    req_valid = 4'b1000;
    req_lock  = 4'b1000;
    drive_cycle("lock_set", 4'b1000);
    req_valid = 4'b1111;
    drive_cycle("lock_rd", 4'b1000);
    req_we    = 4'b1000;
    req_lock  = 4'b0000;
    drive_cycle("lock_wr", 4'b1000);
    req_valid = 4'b0111;
    req_we    = '0;
    drive_cycle("lock_rel", 4'b0001);
    req_valid = '0;
    drive_cycle("drain5", '0);
`endif

    chk("sb_empty", W'(sbq.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
